// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 timing constants, the ns-to-cycle conversion
// and the receiver state encoding. The transmitter side uses the same
// constants so both ends of a loopback agree on the bit timing.
package ws2812_pkg;

  localparam int unsigned DEF_CLK_FREQ    = 50_000_000;
  localparam int unsigned DEF_T_THRESH_NS = 600;
  localparam int unsigned DEF_T_MIN_NS    = 200;
  localparam int unsigned DEF_T_MAX_NS    = 2000;
  localparam int unsigned DEF_T_RESET_NS  = 50000;

  // Whole clock cycles in 'ns' nanoseconds at 'clk_freq' Hz (truncating).
  function automatic int unsigned CYC(input int unsigned clk_freq,
                                      input int unsigned ns);
    return (ns * (clk_freq / 32'd1_000_000)) / 32'd1000;
  endfunction

  typedef enum logic [2:0] {
    ST_SYNC,  // waiting for a full reset gap before trusting the line
    ST_IDLE,  // gap seen, waiting for the first rising edge of a frame
    ST_HIGH,  // measuring a high pulse
    ST_LOW,   // measuring the low time between bits
    ST_ERR    // dropping the partial word after a width violation
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous inputs.
// Ports:
//   i_clk  destination clock
//   i_rst  synchronous active-high reset, both stages cleared to 0
//   i_d    asynchronous input bus
//   o_q    synchronized output (two-cycle latency)
module sync_2ff
  import ws2812_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire NRZ receiver. Measures high-pulse widths on
// din, decodes them to bits, assembles the first 24 bits of a frame
// MSB-first into rgb_data and forwards later bits on dout like a pixel in a
// daisy chain. A long low gap ends the frame.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   din        asynchronous serial input
//   rgb_data   last complete word, bit 23 = first bit received
//   rgb_valid  one-cycle strobe when rgb_data updates
//   frame_end  one-cycle strobe when the reset gap is detected
//   busy       high from the first rising edge of a frame until frame_end
//   bit_error  one-cycle strobe on a width violation or partial word at frame end
//   dout       forwarded serial line (surplus bits only)
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
  parameter int unsigned T_THRESH_NS = DEF_T_THRESH_NS,
  parameter int unsigned T_MIN_NS    = DEF_T_MIN_NS,
  parameter int unsigned T_MAX_NS    = DEF_T_MAX_NS,
  parameter int unsigned T_RESET_NS  = DEF_T_RESET_NS,
  parameter int unsigned FORWARD     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic        rgb_valid,
  output logic        frame_end,
  output logic        busy,
  output logic        bit_error,
  output logic        dout
);

  localparam int unsigned C_RESET = CYC(CLK_FREQ, T_RESET_NS);
  localparam int unsigned CW      = $clog2(C_RESET + 1);

  localparam logic [CW-1:0] L_THRESH   = CW'(CYC(CLK_FREQ, T_THRESH_NS));
  localparam logic [CW-1:0] L_MIN      = CW'(CYC(CLK_FREQ, T_MIN_NS));
  localparam logic [CW-1:0] L_MAX      = CW'(CYC(CLK_FREQ, T_MAX_NS));
  localparam logic [CW-1:0] L_RESET_M1 = CW'(C_RESET - 1);
  localparam logic [CW-1:0] L_ONE      = CW'(1);

  logic            w_din;
  logic            w_bit;

  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_bit_cnt;
  logic [22:0]     r_shift;     // 23 bits suffice: the 24th bit goes straight into rgb_data
  logic            r_own_done;
  logic [23:0]     r_rgb_data;
  logic            r_rgb_valid;
  logic            r_frame_end;
  logic            r_busy;
  logic            r_bit_error;

  sync_2ff #(.WIDTH(1)) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (din),
    .o_q   (w_din)
  );

  // Classification of the pulse just measured; only used on the falling edge.
  assign w_bit = (r_cnt >= L_THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_own_done  <= 1'b0;
      r_rgb_data  <= '0;
      r_rgb_valid <= 1'b0;
      r_frame_end <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_error <= 1'b0;
    end else begin
      r_rgb_valid <= 1'b0;
      r_frame_end <= 1'b0;
      r_bit_error <= 1'b0;

      unique case (r_state)
        ST_SYNC: begin
          // Any high restarts the count so decoding never begins mid-frame.
          if (w_din) begin
            r_cnt <= '0;
          end else if (r_cnt == L_RESET_M1) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (w_din) begin
            r_cnt   <= L_ONE;
            r_busy  <= 1'b1;
            r_state <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (w_din) begin
            if (r_cnt >= L_MAX) begin
              r_bit_error <= 1'b1;
              r_state     <= ST_ERR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
            if (r_cnt < L_MIN) begin
              r_bit_error <= 1'b1;
              r_state     <= ST_ERR;
            end else begin
              r_state <= ST_LOW;
              // Surplus bits are width-checked above but not decoded.
              if (!r_own_done) begin
                r_shift   <= {r_shift[21:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == 5'd23) begin
                  r_rgb_data  <= {r_shift, w_bit};
                  r_rgb_valid <= 1'b1;
                  r_own_done  <= 1'b1;
                end
              end
            end
          end
        end

        ST_LOW: begin
          if (w_din) begin
            r_cnt   <= L_ONE;
            r_state <= ST_HIGH;
          end else if (r_cnt == L_RESET_M1) begin
            r_frame_end <= 1'b1;
            r_bit_error <= (r_bit_cnt != '0) && !r_own_done;
            r_busy      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_own_done  <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_ERR: begin
          r_cnt      <= '0;
          r_bit_cnt  <= '0;
          r_shift    <= '0;
          r_own_done <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_SYNC;
        end

        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign rgb_data  = r_rgb_data;
  assign rgb_valid = r_rgb_valid;
  assign frame_end = r_frame_end;
  assign busy      = r_busy;
  assign bit_error = r_bit_error;
  // Gated straight from the synchronizer output so the forwarded line lags
  // din by exactly the two synchronizer cycles.
  assign dout = (FORWARD != 0) && r_own_done && w_din;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx. Stimulus changes din two time
// units after a rising clock edge; a negedge monitor counts output strobes
// and compares dout against din delayed by two cycles inside a window.
module tb_ws2812_rx;

  logic        clk;
  logic        rst;
  logic        din;
  logic [23:0] rgb_data;
  logic        rgb_valid;
  logic        frame_end;
  logic        busy;
  logic        bit_error;
  logic        dout;

  int vectors    = 0;
  int miscompares = 0;

  int cyc = 0;
  int t_fall = 0;
  int t_valid = 0;
  int n_valid, n_fe, n_err, n_fe_err, dout_hi, dout_mis;
  logic clr_req = 1'b0;
  logic chk_dout = 1'b0;
  logic [1:0] hist = '0;

  ws2812_rx #(
    .CLK_FREQ    (50_000_000),
    .T_THRESH_NS (600),
    .T_MIN_NS    (200),
    .T_MAX_NS    (2000),
    .T_RESET_NS  (50000),
    .FORWARD     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .rgb_data  (rgb_data),
    .rgb_valid (rgb_valid),
    .frame_end (frame_end),
    .busy      (busy),
    .bit_error (bit_error),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr_req) begin
      n_valid = 0; n_fe = 0; n_err = 0; n_fe_err = 0; dout_hi = 0; dout_mis = 0;
    end else begin
      if (rgb_valid) begin n_valid++; t_valid = cyc; end
      if (frame_end) n_fe++;
      if (bit_error) n_err++;
      if (frame_end && bit_error) n_fe_err++;
      if (dout) dout_hi++;
      if (chk_dout && (dout !== hist[1])) dout_mis++;
    end
    hist = {hist[0], din};
  end

  // All drive tasks start and end at posedge+2.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    clr_req = 1'b1;
    @(posedge clk); #2;
    clr_req = 1'b0;
  endtask

  task automatic send_bit_w(input int hi, input int lo);
    hold(1'b1, hi);
    t_fall = cyc;
    hold(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_bit_w(40, 22);
    else   send_bit_w(20, 42);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++; if (rgb_data !== 24'h0) begin miscompares++; $display("FAIL reset_rgb_data: got %h expected %h", rgb_data, 24'h0); end
    vectors++; if (rgb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rgb_valid: got %b expected 0", rgb_valid); end
    vectors++; if (frame_end !== 1'b0) begin miscompares++; $display("FAIL reset_frame_end: got %b expected 0", frame_end); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (bit_error !== 1'b0) begin miscompares++; $display("FAIL reset_bit_error: got %b expected 0", bit_error); end
    vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout: got %b expected 0", dout); end
    rst = 1'b0;
    clear_mon();
    hold(1'b0, 2600);
    vectors++; if (n_fe !== 0) begin miscompares++; $display("FAIL sync_no_frame_end: got %0d expected 0", n_fe); end
  endtask

  task automatic test_loopback();
    int lat;
    clear_mon();
    send_bits(24'hFF00FF, 24);
    lat = t_valid - t_fall;
    vectors++; if (lat < 1 || lat > 3) begin miscompares++; $display("FAIL loop_latency: got %0d expected 1..3", lat); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL loop_busy: got %b expected 1", busy); end
    hold(1'b0, 2600);
    vectors++; if (rgb_data !== 24'hFF00FF) begin miscompares++; $display("FAIL loop_data: got %h expected %h", rgb_data, 24'hFF00FF); end
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL loop_valid_count: got %0d expected 1", n_valid); end
    vectors++; if (dout_hi !== 0) begin miscompares++; $display("FAIL loop_dout_quiet: got %0d expected 0", dout_hi); end
    vectors++; if (n_fe !== 1) begin miscompares++; $display("FAIL loop_frame_end: got %0d expected 1", n_fe); end
    vectors++; if (n_err !== 0) begin miscompares++; $display("FAIL loop_no_error: got %0d expected 0", n_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL loop_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int h0;
    clear_mon();
    send_bits(24'h00FF00, 24);
    vectors++; if (dout_hi !== 0) begin miscompares++; $display("FAIL b2b_dout_first_word: got %0d expected 0", dout_hi); end
    vectors++; if (rgb_data !== 24'h00FF00) begin miscompares++; $display("FAIL b2b_data: got %h expected %h", rgb_data, 24'h00FF00); end
    h0 = dout_hi;
    chk_dout = 1'b1;
    send_bits(24'h0000FF, 24);
    hold(1'b0, 2600);
    chk_dout = 1'b0;
    vectors++; if (dout_mis !== 0) begin miscompares++; $display("FAIL b2b_dout_delay: got %0d mismatched cycles expected 0", dout_mis); end
    vectors++; if (dout_hi - h0 !== 640) begin miscompares++; $display("FAIL b2b_dout_high_cycles: got %0d expected 640", dout_hi - h0); end
    vectors++; if (rgb_data !== 24'h00FF00) begin miscompares++; $display("FAIL b2b_data_kept: got %h expected %h", rgb_data, 24'h00FF00); end
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL b2b_valid_count: got %0d expected 1", n_valid); end
    vectors++; if (n_fe !== 1) begin miscompares++; $display("FAIL b2b_frame_end: got %0d expected 1", n_fe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_boundary_widths();
    clear_mon();
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    send_bit_w(29, 33);   // 0
    send_bit_w(30, 32);   // 1
    send_bit_w(10, 52);   // 0, shortest legal
    send_bit_w(100, 22);  // 1, longest legal
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    hold(1'b0, 2600);
    vectors++; if (rgb_data !== 24'hFFF500) begin miscompares++; $display("FAIL width_data: got %h expected %h", rgb_data, 24'hFFF500); end
    vectors++; if (n_err !== 0) begin miscompares++; $display("FAIL width_legal_no_error: got %0d expected 0", n_err); end
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL width_valid_count: got %0d expected 1", n_valid); end

    clear_mon();
    send_bit_w(9, 50);
    vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL width_short_error: got %0d expected 1", n_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL width_short_busy: got %b expected 0", busy); end
    hold(1'b0, 2600);

    clear_mon();
    send_bit_w(101, 50);
    vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL width_long_error: got %0d expected 1", n_err); end
    hold(1'b0, 2600);

    clear_mon();
    send_bits(24'h123456, 24);
    hold(1'b0, 2600);
    vectors++; if (rgb_data !== 24'h123456) begin miscompares++; $display("FAIL recovery_data: got %h expected %h", rgb_data, 24'h123456); end
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL recovery_valid: got %0d expected 1", n_valid); end
    vectors++; if (n_err !== 0) begin miscompares++; $display("FAIL recovery_no_error: got %0d expected 0", n_err); end
  endtask

  task automatic test_partial_word();
    clear_mon();
    send_bits(24'hABC000, 12);
    hold(1'b0, 2600);
    vectors++; if (n_fe !== 1) begin miscompares++; $display("FAIL partial_frame_end: got %0d expected 1", n_fe); end
    vectors++; if (n_fe_err !== 1) begin miscompares++; $display("FAIL partial_error_with_frame_end: got %0d expected 1", n_fe_err); end
    vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL partial_error_count: got %0d expected 1", n_err); end
    vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL partial_no_valid: got %0d expected 0", n_valid); end
    vectors++; if (rgb_data !== 24'h123456) begin miscompares++; $display("FAIL partial_data_kept: got %h expected %h", rgb_data, 24'h123456); end
  endtask

  task automatic test_long_low();
    logic [23:0] w;
    w = 24'hDEADBE;
    clear_mon();
    for (int i = 23; i >= 0; i--) begin
      if (i == 12) send_bit_w(w[i] ? 40 : 20, 2499);
      else         send_bit(w[i]);
    end
    vectors++; if (n_fe !== 0) begin miscompares++; $display("FAIL long_low_not_reset: got %0d expected 0", n_fe); end
    vectors++; if (rgb_data !== 24'hDEADBE) begin miscompares++; $display("FAIL long_low_data: got %h expected %h", rgb_data, 24'hDEADBE); end
    hold(1'b0, 2600);
    vectors++; if (n_fe !== 1) begin miscompares++; $display("FAIL long_low_frame_end: got %0d expected 1", n_fe); end
  endtask

  task automatic test_mid_frame_start();
    rst = 1'b1;
    send_bit(1'b1);
    hold(1'b1, 10);
    rst = 1'b0;
    hold(1'b1, 10);
    hold(1'b0, 30);
    clear_mon();
    for (int i = 0; i < 29; i++) send_bit(i[0]);
    send_bit_w(40, 2499);
    for (int i = 0; i < 29; i++) send_bit(~i[0]);
    send_bit_w(40, 2499);
    vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL midframe_no_decode: got %0d expected 0", n_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midframe_busy: got %b expected 0", busy); end
    vectors++; if (n_fe + n_err !== 0) begin miscompares++; $display("FAIL midframe_no_strobes: got %0d expected 0", n_fe + n_err); end
    hold(1'b0, 2600);
    send_bits(24'h5A5A5A, 24);
    hold(1'b0, 2600);
    vectors++; if (rgb_data !== 24'h5A5A5A) begin miscompares++; $display("FAIL midframe_after_sync: got %h expected %h", rgb_data, 24'h5A5A5A); end
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL midframe_valid: got %0d expected 1", n_valid); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_bits(24'hF0F0F0, 10);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(posedge clk); #2;
    vectors++; if (rgb_data !== 24'h0) begin miscompares++; $display("FAIL rstmid_data: got %h expected %h", rgb_data, 24'h0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    vectors++; if ({rgb_valid, frame_end, bit_error, dout} !== 4'b0) begin miscompares++; $display("FAIL rstmid_strobes: got %b expected 0000", {rgb_valid, frame_end, bit_error, dout}); end
    rst = 1'b0;
    hold(1'b0, 2600);
    vectors++; if (n_err !== 0) begin miscompares++; $display("FAIL rstmid_silent: got %0d expected 0", n_err); end
    send_bits(24'hAABBCC, 24);
    hold(1'b0, 2600);
    vectors++; if (rgb_data !== 24'hAABBCC) begin miscompares++; $display("FAIL rstmid_clean_frame: got %h expected %h", rgb_data, 24'hAABBCC); end
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL rstmid_valid: got %0d expected 1", n_valid); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_boundary_widths();
    test_partial_word();
    test_long_low();
    test_mid_frame_start();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
